vga_price_chart: RTL and testbench
==================================

# vga_price_chart

Scrolling multi-channel price-history renderer for the 640x480 VGA path. Captures up to NCH prices per accepted sample into a circular history buffer. Each frame, it draws the newest samples as step-connected traces, with spread/progress bars and a halt overlay. It replaces the single-instant line display and sits between the trading core and the VGA timing generator.

## Interface
- NCH, 2: price channels, 1..4
- PRICE_W, 8: price width
- DEPTH, 64: history buffer entries, power of 2
- COL_SHIFT, 3: each sample occupies 2^COL_SHIFT pixel columns; (DEPTH-1)<<COL_SHIFT ≤ 640
- Y_SHIFT, 1: price-to-row scale (row offset = price<<Y_SHIFT)

Ports:
- clk_25mhz  in  1  pixel clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- video_on  in  1  active-video flag, aligned with h_cnt/v_cnt
- h_cnt, v_cnt  in  10 each  pixel coordinates
- sample_valid  in  1  sample strobe
- sample_ready  out  1  sample accepted when valid&ready
- prices  in  NCH*PRICE_W  channel c at bits [c*PRICE_W +: PRICE_W]
- trade_count, spread  in  8 each  bar values
- halt_signal  in  1  market halt
- freeze  in  1  hold history; stop capture
- R, G, B  out  4 each  registered colour

## Operation
- sample_ready = !freeze && !halt_signal, combinational.
- On accept, write prices to buf[wr_ptr]; wr_ptr increments mod DEPTH; count saturates at DEPTH.
- Frame snapshot: on the cycle with h_cnt==0 && v_cnt==0, latch snap_ptr=wr_ptr and snap_cnt=min(count, DEPTH-1).
  - A sample accepted in that same cycle is excluded (pre-write values latched).
- Window is the snap_cnt newest samples, oldest at left.
- Column index k = h_cnt>>COL_SHIFT, valid for k < DEPTH-1.
  - Entry shown at column k is buf[(snap_ptr-(DEPTH-1)+k) mod DEPTH].
  - Column k is empty when k < (DEPTH-1)-snap_cnt.
- Row for price p: y = (p<<Y_SHIFT) ≥ 480 ? 0 : 479-(p<<Y_SHIFT), computed 11-bit before compare.
- Channel c is lit at column k if v_cnt lies in [min(y_k,y_prev), max(y_k,y_prev)].
  - y_prev is channel c's row at column k-1.
  - y_prev = y_k for the leftmost non-empty column.
  - This draws the vertical step join at each sample boundary.
- Channel colours (package): c0 green 0F0, c1 red F00, c2 blue 00F, c3 yellow FF0. The lowest lit index wins.
- Bars, widths computed 11-bit so there is no wrap:
  - v_cnt 460..469 and h_cnt < spread*5: red F00.
  - v_cnt 470..479 and h_cnt < trade_count*6: green 0F0.
  - Bars override traces.
- halt_signal=1: every active pixel is 8,8,A; traces and bars are suppressed.
- Blanking: R=G=B=0 whenever the delayed video_on is 0, including during halt.
- More than one accept per frame may update the leftmost columns mid-frame. This is allowed.
- At most one accept per frame is tear-free.

## Timing
- Pixel pipeline latency is 3 clocks: h/v in at cycle n produce RGB at n+3.
  - Stage 1: address/column decode.
  - Stage 2: synchronous buffer read.
  - Stage 3: compare and colour.
  - The timing generator delays hsync/vsync by 3.
- video_on and halt_signal are pipelined alongside pixel data.
- Buffer read-during-write returns old data.
- Reset: wr_ptr=0, count=0, snap_ptr=0, snap_cnt=0, all pipeline registers 0, R=G=B=0.
  - Deasserting reset mid-frame gives blank traces until the next snapshot.
  - Bars and halt respond within 3 clocks.

## Structure
- vga_chart_pkg holds the colour constants, screen constants (480 rows, 640 cols, bar rows 460/470), and the bar multipliers 5 and 6.
- One sub-module: chart_history_ram.
  - DEPTH x NCH*PRICE_W.
  - One write port, one registered read port.
  - Reads entries k and k-1 each column via a held previous-word register.
  - Infers block RAM.

## Test plan
- Reset, then an all-pixel frame sweep: RGB=0 everywhere except bars, since spread=0 and trade_count=0 give zero-width bars.
- Write a single sample c0=100, then the next frame: green lit at v_cnt=279, only in column 62 (h 496..503). All other columns are blank.
- Two samples 100 then 120 on c0: column 62 lit at v 239..279 (step join); column 61 lit at 279 only.
- Price 250 with Y_SHIFT=1: 500≥480 clamps to row 0; no 10-bit wrap artifacts.
- freeze=1 with sample_valid held: sample_ready=0, wr_ptr unchanged. halt_signal=1 gives 8,8,A in active area and 0 in blanking, 3 clocks after assertion.
- Accept 70 samples (wrap): the window shows samples 8..70. A sample accepted exactly at h=0,v=0 appears the next frame only.

Source files
------------

// File: rtl/vga_price_chart_pkg.sv
// Shared screen geometry, bar scaling, colour constants and pixel-pipeline types
// for the scrolling price chart.
package vga_chart_pkg;

    localparam int SCR_ROWS    = 480;
    localparam int SCR_COLS    = 640;
    localparam int BAR_RED_ROW = 460;
    localparam int BAR_GRN_ROW = 470;
    localparam int BAR_H       = 10;
    localparam int SPREAD_MUL  = 5;
    localparam int TRADE_MUL   = 6;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_OFF    = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t RGB_GREEN  = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb_t RGB_RED    = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb_t RGB_BLUE   = '{r: 4'h0, g: 4'h0, b: 4'hF};
    localparam rgb_t RGB_YELLOW = '{r: 4'hF, g: 4'hF, b: 4'h0};
    localparam rgb_t RGB_HALT   = '{r: 4'h8, g: 4'h8, b: 4'hA};

    // Per-pixel control carried alongside the buffer read.
    typedef struct packed {
        logic       vid;
        logic       halt;
        logic       trace;
        logic       leftmost;
        logic       bar_red;
        logic       bar_grn;
        logic [9:0] v;
    } pix_t;

    function automatic rgb_t ch_colour(input int c);
        case (c)
            0:       return RGB_GREEN;
            1:       return RGB_RED;
            2:       return RGB_BLUE;
            default: return RGB_YELLOW;
        endcase
    endfunction

    // Scaled price to screen row; anything off the top clamps to row 0.
    function automatic logic [10:0] price_row(input logic [10:0] scaled);
        if (scaled >= 11'(SCR_ROWS))
            return 11'd0;
        return 11'(SCR_ROWS - 1) - scaled;
    endfunction

endpackage

// File: rtl/vga_price_chart_if.sv
// Sample stream from the trading core into the chart: one multi-channel price
// word per valid&ready beat.
interface vga_price_chart_if #(
    parameter int NCH     = 2,
    parameter int PRICE_W = 8
);
    logic                   sample_valid;
    logic                   sample_ready;
    logic [NCH*PRICE_W-1:0] prices;

    modport master (output sample_valid, output prices, input  sample_ready);
    modport slave  (input  sample_valid, input  prices, output sample_ready);
endinterface

// File: rtl/chart_history_ram.sv
// Circular price history: one write port, one registered read port plus a held copy of the previous column's word.
// Latency: read data one clock after rd_addr; prev_dat updates on rd_adv with the word being replaced.
// Backpressure: none; writes always land, read-during-write returns the old word.
module chart_history_ram #(
    parameter int DEPTH = 64,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_adv,
    output logic [DW-1:0] rd_dat,
    output logic [DW-1:0] prev_dat
);

    logic [DW-1:0] mem [DEPTH];

    // Kept free of reset so the array and output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_dat;
        rd_dat <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev_dat <= '0;
        else if (rd_adv)
            prev_dat <= rd_dat;
    end

endmodule

// File: rtl/vga_price_chart.sv
// Scrolling multi-channel price-history renderer with spread/trade bars and halt overlay.
// Latency: h/v/video_on in at cycle n give registered R/G/B at n+3.
// Backpressure: sample_ready drops while frozen or halted; the pixel path never stalls.
module vga_price_chart
    import vga_chart_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int PRICE_W   = 8,
    parameter int DEPTH     = 64,
    parameter int COL_SHIFT = 3,
    parameter int Y_SHIFT   = 1
) (
    input  logic                clk_25mhz,
    input  logic                rst_n,
    input  logic                video_on,
    input  logic [9:0]          h_cnt,
    input  logic [9:0]          v_cnt,
    vga_price_chart_if.slave    smp,
    input  logic [7:0]          trade_count,
    input  logic [7:0]          spread,
    input  logic                halt_signal,
    input  logic                freeze,
    output logic [3:0]          R,
    output logic [3:0]          G,
    output logic [3:0]          B
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int DW    = NCH * PRICE_W;
    localparam int WIN   = DEPTH - 1;
    localparam logic [9:0] COL_MASK = 10'((1 << COL_SHIFT) - 1);

    typedef logic [AW-1:0] ptr_t;

    logic             accept;
    logic             frame_start;
    ptr_t             wr_ptr;
    logic [CNT_W-1:0] count;
    ptr_t             snap_ptr;
    ptr_t             snap_cnt;

    assign smp.sample_ready = !freeze && !halt_signal;
    assign accept           = smp.sample_valid && smp.sample_ready;
    assign frame_start      = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // Snapshot takes the pre-write pointer, so a same-cycle accept waits a frame.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            count    <= '0;
            snap_ptr <= '0;
            snap_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != CNT_W'(DEPTH))
                    count <= count + 1'b1;
            end
            if (frame_start) begin
                snap_ptr <= wr_ptr;
                snap_cnt <= (count >= CNT_W'(WIN)) ? ptr_t'(WIN) : count[AW-1:0];
            end
        end
    end

    // ---------------- stage 1: column decode and bar hit ----------------
    logic [9-COL_SHIFT:0] col;
    logic [10:0]          col_w;
    logic [10:0]          first_k;
    pix_t                 s1_nxt;
    pix_t                 s1;
    pix_t                 s2;
    ptr_t                 s1_addr;
    logic                 s1_new_col;

    assign col     = h_cnt[9:COL_SHIFT];
    assign col_w   = 11'(col);
    assign first_k = 11'(WIN) - 11'(snap_cnt);

    always_comb begin
        s1_nxt          = '0;
        s1_nxt.vid      = video_on;
        s1_nxt.halt     = halt_signal;
        s1_nxt.v        = v_cnt;
        s1_nxt.trace    = (col_w < 11'(WIN)) && (col_w >= first_k) && (h_cnt < 10'(SCR_COLS));
        s1_nxt.leftmost = (col_w == first_k);
        s1_nxt.bar_red  = (v_cnt >= 10'(BAR_RED_ROW)) && (v_cnt < 10'(BAR_RED_ROW + BAR_H))
                          && (11'(h_cnt) < 11'(spread) * 11'(SPREAD_MUL));
        s1_nxt.bar_grn  = (v_cnt >= 10'(BAR_GRN_ROW)) && (v_cnt < 10'(BAR_GRN_ROW + BAR_H))
                          && (11'(h_cnt) < 11'(trade_count) * 11'(TRADE_MUL));
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s1_addr    <= '0;
            s1_new_col <= 1'b0;
            s2         <= '0;
        end else begin
            s1         <= s1_nxt;
            s1_addr    <= snap_ptr - ptr_t'(WIN) + ptr_t'(col);
            s1_new_col <= ((h_cnt & COL_MASK) == 10'd0);
            s2         <= s1;
        end
    end

    // ---------------- stage 2: buffer read ----------------
    logic [DW-1:0] rd_dat;
    logic [DW-1:0] prev_dat;

    chart_history_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk      (clk_25mhz),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_addr  (wr_ptr),
        .wr_dat   (smp.prices),
        .rd_addr  (s1_addr),
        .rd_adv   (s1_new_col),
        .rd_dat   (rd_dat),
        .prev_dat (prev_dat)
    );

    // ---------------- stage 3: compare and colour ----------------
    function automatic logic chan_lit(input logic [PRICE_W-1:0] p,
                                      input logic [PRICE_W-1:0] pp,
                                      input logic               left,
                                      input logic [10:0]        v);
        logic [10:0] y;
        logic [10:0] yp;
        logic [10:0] lo;
        logic [10:0] hi;
        y  = price_row(11'(p) << Y_SHIFT);
        yp = left ? y : price_row(11'(pp) << Y_SHIFT);
        lo = (y < yp) ? y : yp;
        hi = (y < yp) ? yp : y;
        return (v >= lo) && (v <= hi);
    endfunction

    logic [NCH-1:0] lit;
    rgb_t           rgb_nxt;
    rgb_t           rgb_q;

    always_comb begin
        lit = '0;
        for (int c = 0; c < NCH; c++)
            lit[c] = s2.trace && chan_lit(rd_dat[c*PRICE_W +: PRICE_W],
                                          prev_dat[c*PRICE_W +: PRICE_W],
                                          s2.leftmost, {1'b0, s2.v});
    end

    // Later assignments take priority: bars over traces, halt over all, blanking last.
    always_comb begin
        rgb_nxt = RGB_OFF;
        for (int c = NCH - 1; c >= 0; c--)
            if (lit[c])
                rgb_nxt = ch_colour(c);
        if (s2.bar_red)
            rgb_nxt = RGB_RED;
        if (s2.bar_grn)
            rgb_nxt = RGB_GREEN;
        if (s2.halt)
            rgb_nxt = RGB_HALT;
        if (!s2.vid)
            rgb_nxt = RGB_OFF;
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n)
            rgb_q <= RGB_OFF;
        else
            rgb_q <= rgb_nxt;
    end

    assign R = rgb_q.r;
    assign G = rgb_q.g;
    assign B = rgb_q.b;

endmodule

// File: tb/tb_vga_price_chart.sv
// Directed bench for vga_price_chart: scans selected rows and checks hand-computed pixels and counts.
module tb_vga_price_chart;

    localparam logic [11:0] PX_OFF  = 12'h000;
    localparam logic [11:0] PX_GRN  = 12'h0F0;
    localparam logic [11:0] PX_RED  = 12'hF00;
    localparam logic [11:0] PX_HALT = 12'h88A;

    logic       clk_25mhz = 1'b0;
    logic       rst_n;
    logic       video_on;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [7:0] trade_count;
    logic [7:0] spread;
    logic       halt_signal;
    logic       freeze;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] row_px [640];

    vga_price_chart_if #(.NCH(2), .PRICE_W(8)) smp_if ();

    vga_price_chart #(
        .NCH       (2),
        .PRICE_W   (8),
        .DEPTH     (64),
        .COL_SHIFT (3),
        .Y_SHIFT   (1)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .rst_n       (rst_n),
        .video_on    (video_on),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .smp         (smp_if),
        .trade_count (trade_count),
        .spread      (spread),
        .halt_signal (halt_signal),
        .freeze      (freeze),
        .R           (R),
        .G           (G),
        .B           (B)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic idle();
        h_cnt    = 10'd700;
        v_cnt    = 10'd500;
        video_on = 1'b0;
    endtask

    task automatic push(input logic [7:0] c0, input logic [7:0] c1);
        smp_if.prices       = {c1, c0};
        smp_if.sample_valid = 1'b1;
        tick();
        smp_if.sample_valid = 1'b0;
    endtask

    task automatic snap();
        h_cnt    = 10'd0;
        v_cnt    = 10'd0;
        video_on = 1'b1;
        tick();
        idle();
        tick();
    endtask

    // Pixel j driven in iteration j appears on R/G/B two iterations later.
    task automatic scan_row(input int vv, input logic vid);
        for (int j = 0; j < 642; j++) begin
            if (j < 640) begin
                h_cnt    = 10'(j);
                v_cnt    = 10'(vv);
                video_on = vid;
            end else begin
                idle();
            end
            tick();
            if (j >= 2)
                row_px[j-2] = {R, G, B};
        end
    endtask

    function automatic int cnt_nz();
        int n = 0;
        foreach (row_px[i]) if (row_px[i] != PX_OFF) n++;
        return n;
    endfunction

    function automatic int cnt_eq(input logic [11:0] val);
        int n = 0;
        foreach (row_px[i]) if (row_px[i] == val) n++;
        return n;
    endfunction

    initial begin
        int blank;
        rst_n               = 1'b0;
        smp_if.sample_valid = 1'b0;
        smp_if.prices       = '0;
        trade_count         = 8'd0;
        spread              = 8'd255;
        halt_signal         = 1'b0;
        freeze              = 1'b0;
        h_cnt               = 10'd5;
        v_cnt               = 10'd465;
        video_on            = 1'b1;

        // Reset state: a full-width bar pixel is driven but reset holds RGB at 0.
        repeat (4) tick();
        check("reset_rgb", 32'({R, G, B}), 32'(PX_OFF));
        check("reset_ready", 32'(smp_if.sample_ready), 32'd1);
        spread = 8'd0;
        idle();
        rst_n = 1'b1;
        tick();

        // Empty history, zero-width bars: subsampled frame is entirely dark.
        snap();
        blank = 0;
        for (int v = 0; v < 480; v += 16) begin
            scan_row(v, 1'b1);
            blank += cnt_nz();
        end
        scan_row(479, 1'b1);
        blank += cnt_nz();
        check("blank_frame", 32'(blank), 32'd0);

        // One sample c0=100 (row 279), c1=0 (row 479) lands in column 62.
        push(8'd100, 8'd0);
        snap();
        scan_row(279, 1'b1);
        check("s1_r279_cnt", 32'(cnt_nz()), 32'd8);
        check("s1_r279_h496", 32'(row_px[496]), 32'(PX_GRN));
        check("s1_r279_h503", 32'(row_px[503]), 32'(PX_GRN));
        check("s1_r279_h495", 32'(row_px[495]), 32'(PX_OFF));
        check("s1_r279_h504", 32'(row_px[504]), 32'(PX_OFF));
        scan_row(278, 1'b1);
        check("s1_r278_cnt", 32'(cnt_nz()), 32'd0);
        scan_row(479, 1'b1);
        check("s1_r479_red", 32'(cnt_eq(PX_RED)), 32'd8);

        // Second sample 120 (row 239): step join 239..279 in column 62.
        push(8'd120, 8'd0);
        snap();
        scan_row(279, 1'b1);
        check("s2_r279_cnt", 32'(cnt_nz()), 32'd16);
        check("s2_r279_h488", 32'(row_px[488]), 32'(PX_GRN));
        scan_row(239, 1'b1);
        check("s2_r239_cnt", 32'(cnt_nz()), 32'd8);
        check("s2_r239_h496", 32'(row_px[496]), 32'(PX_GRN));
        scan_row(260, 1'b1);
        check("s2_r260_cnt", 32'(cnt_nz()), 32'd8);
        scan_row(238, 1'b1);
        check("s2_r238_cnt", 32'(cnt_nz()), 32'd0);
        scan_row(479, 1'b1);
        check("s2_r479_red", 32'(cnt_eq(PX_RED)), 32'd16);

        // c0=250 clamps to row 0 (join 0..239); c1=200 is row 79 (join 79..479).
        push(8'd250, 8'd200);
        snap();
        scan_row(0, 1'b1);
        check("s3_r0_cnt", 32'(cnt_nz()), 32'd8);
        check("s3_r0_h496", 32'(row_px[496]), 32'(PX_GRN));
        scan_row(100, 1'b1);
        check("s3_r100_prio", 32'(row_px[496]), 32'(PX_GRN));
        check("s3_r100_cnt", 32'(cnt_nz()), 32'd8);
        scan_row(300, 1'b1);
        check("s3_r300_h496", 32'(row_px[496]), 32'(PX_RED));
        check("s3_r300_cnt", 32'(cnt_nz()), 32'd8);
        scan_row(240, 1'b1);
        check("s3_r240_h488", 32'(row_px[488]), 32'(PX_GRN));
        check("s3_r240_h496", 32'(row_px[496]), 32'(PX_RED));
        check("s3_r240_cnt", 32'(cnt_nz()), 32'd16);

        // Bars: spread 3 -> 15 px; trade 200 -> 1200 px, full row, over the trace.
        spread      = 8'd3;
        trade_count = 8'd200;
        scan_row(465, 1'b1);
        check("bar_sp_h14", 32'(row_px[14]), 32'(PX_RED));
        check("bar_sp_h15", 32'(row_px[15]), 32'(PX_OFF));
        check("bar_sp_red", 32'(cnt_eq(PX_RED)), 32'd23);
        scan_row(475, 1'b1);
        check("bar_tc_full", 32'(cnt_eq(PX_GRN)), 32'd640);
        check("bar_tc_h496", 32'(row_px[496]), 32'(PX_GRN));
        spread = 8'd255;
        scan_row(465, 1'b1);
        check("bar_sp_full", 32'(cnt_eq(PX_RED)), 32'd640);
        spread      = 8'd0;
        trade_count = 8'd0;

        // Halt: blocks samples, overlay appears exactly 3 clocks after assertion.
        h_cnt    = 10'd300;
        v_cnt    = 10'd100;
        video_on = 1'b1;
        repeat (4) tick();
        check("halt_pre", 32'({R, G, B}), 32'(PX_OFF));
        halt_signal = 1'b1;
        #1;
        check("halt_ready", 32'(smp_if.sample_ready), 32'd0);
        tick();
        tick();
        check("halt_lat2", 32'({R, G, B}), 32'(PX_OFF));
        tick();
        check("halt_lat3", 32'({R, G, B}), 32'(PX_HALT));
        push(8'd30, 8'd30);
        scan_row(100, 1'b1);
        check("halt_active", 32'(cnt_eq(PX_HALT)), 32'd640);
        scan_row(100, 1'b0);
        check("halt_blank", 32'(cnt_nz()), 32'd0);
        halt_signal = 1'b0;
        idle();

        // Freeze with valid held: nothing accepted, display unchanged.
        freeze              = 1'b1;
        smp_if.prices       = {8'd50, 8'd50};
        smp_if.sample_valid = 1'b1;
        #1;
        check("freeze_ready", 32'(smp_if.sample_ready), 32'd0);
        repeat (5) tick();
        smp_if.sample_valid = 1'b0;
        freeze              = 1'b0;
        snap();
        scan_row(300, 1'b1);
        check("frz_r300_cnt", 32'(cnt_nz()), 32'd8);
        check("frz_r300_h496", 32'(row_px[496]), 32'(PX_RED));
        scan_row(279, 1'b1);
        check("frz_r279_cnt", 32'(cnt_nz()), 32'd24);
        check("frz_r279_h480", 32'(row_px[480]), 32'(PX_GRN));

        // Wrap: 70 samples c0=i; window holds samples 8..70.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 70; i++)
            push(8'(i), 8'd0);
        snap();
        scan_row(463, 1'b1);
        check("wr_r463_h0", 32'(row_px[0]), 32'(PX_GRN));
        check("wr_r463_h8", 32'(row_px[8]), 32'(PX_GRN));
        check("wr_r463_h16", 32'(row_px[16]), 32'(PX_OFF));
        check("wr_r463_cnt", 32'(cnt_nz()), 32'd16);
        scan_row(465, 1'b1);
        check("wr_r465_cnt", 32'(cnt_nz()), 32'd0);
        scan_row(339, 1'b1);
        check("wr_r339_cnt", 32'(cnt_nz()), 32'd8);
        check("wr_r339_h496", 32'(row_px[496]), 32'(PX_GRN));
        scan_row(341, 1'b1);
        check("wr_r341_cnt", 32'(cnt_nz()), 32'd16);
        scan_row(479, 1'b1);
        check("wr_r479_red", 32'(cnt_eq(PX_RED)), 32'd504);

        // Sample 71 accepted on the snapshot cycle shows only from the next frame.
        h_cnt               = 10'd0;
        v_cnt               = 10'd0;
        video_on            = 1'b1;
        smp_if.prices       = {8'd0, 8'd71};
        smp_if.sample_valid = 1'b1;
        tick();
        smp_if.sample_valid = 1'b0;
        idle();
        tick();
        scan_row(339, 1'b1);
        check("ex_r339_h496", 32'(row_px[496]), 32'(PX_GRN));
        scan_row(337, 1'b1);
        check("ex_r337_cnt", 32'(cnt_nz()), 32'd0);
        snap();
        scan_row(337, 1'b1);
        check("nx_r337_h496", 32'(row_px[496]), 32'(PX_GRN));
        check("nx_r337_cnt", 32'(cnt_nz()), 32'd8);
        scan_row(339, 1'b1);
        check("nx_r339_h488", 32'(row_px[488]), 32'(PX_GRN));
        check("nx_r339_cnt", 32'(cnt_nz()), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
